ysyx_24110015_idex_reg: RTL and testbench
=========================================

Name: ysyx_24110015_idex_reg

Overview:
- IDU→EXU pipeline stage register for the NPC core.
- Resolves each source operand from the forward-check results: forwarded value, register-file data, or stall.
- Holds the decoded instruction under a valid/ready handshake. Inserts bubbles on load-use / unforwardable RAW.
- Supports flush on redirect and counts hazard-stall cycles for perf reporting.

Parameters:
- CTRL_W, 32, width of the opaque decoded-control bundle passed IDU→EXU.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  IDU holds a decoded instruction
- in_ready  out  1  stage accepts the IDU instruction this cycle
- in_pc  in  32  PC of the IDU instruction
- in_ctrl  in  CTRL_W  decoded control bundle
- rf_rdata1 / rf_rdata2  in  32 each  register-file read data
- rs1_raw / rs2_raw  in  1 each  RAW hazard present on the source
- rs1_forward / rs2_forward  in  1 each  hazard resolvable by forwarding
- rs1_value / rs2_value  in  32 each  forwarded values
- idu_processing  out  1  = in_valid; qualifies the forward check
- flush  in  1  redirect: kill the IDU and stage contents
- out_valid  out  1  stage holds a valid instruction for EXU
- out_ready  in  1  EXU accepts
- out_pc  out  32  latched PC
- out_src1 / out_src2  out  32 each  latched resolved operands
- out_ctrl  out  CTRL_W  latched control bundle
- stall_cnt  out  CNT_W  hazard-stall cycle count

Behaviour:
- Reset (reset_n low, asynchronous) clears every register and output to 0: out_valid, out_pc, out_src*, out_ctrl, stall_cnt. On release, operation starts at the first rising edge.
- Operand select, per source, combinational:
  - src = rsN_forward ? rsN_value : rf_rdata.
  - Source N is unresolved when rsN_raw & ~rsN_forward.
- Hazard definition: hazard = in_valid & (rs1 unresolved | rs2 unresolved).
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- Fire: fire_in = in_valid & in_ready. On fire_in, the next edge latches in_pc, in_ctrl and both resolved operands, and sets out_valid = 1.
- Drain: if out_valid & out_ready & ~fire_in, out_valid clears to 0. A stalled hazard with out_ready therefore emits a bubble.
- Hold: while out_valid & ~out_ready, all out_* registers hold stable (AXI-style: no change while valid and not ready).
- Flush, highest priority:
  - out_valid clears to 0 at the next edge.
  - in_ready is 0 that cycle, so no capture occurs.
  - Data registers may hold stale values.
  - If flush coincides with out_ready, no transfer is considered lost; EXU sampled it that cycle.
- Throughput: one instruction per cycle when there is no hazard and out_ready = 1. Latency is one cycle from fire_in to out_valid.
- stall_cnt:
  - Increments by 1 each cycle with hazard & ~flush.
  - Wraps at 2^CNT_W-1 → 0.
  - Not cleared by flush.
- Simultaneous drain + fire: out_valid stays 1 and the new contents load (back-to-back).
- Raw without in_valid is ignored: no stall and no count.
- The lone ctrl field is opaque; no decoding inside this block.

Decomposition:
- Shared package ysyx_24110015_pkg holds:
  - XLEN = 32
  - typedef idex_ctrl_t, width CTRL_W
  - localparam RESET_PC_ZERO = 0 for out_pc reset
- One natural sub-module: ysyx_24110015_operand_sel. It is purely combinational per source, taking raw, forward, value and rf_rdata, and producing resolved src and unresolved. It is instantiated twice.
- The rest, namely the handshake, registers and counter, is a single always_ff in the top.

Test Plan:
- Reset then stream: in_valid = 1, no raw, out_ready = 1, pcs 0x8000_0000..0x8000_000C.
  - Expect out_pc to follow one cycle later, out_valid continuous, stall_cnt = 0.
- Forward select: rs1_raw = 1, rs1_forward = 1, rs1_value = 0xDEAD_BEEF, rf_rdata1 = 0x1234.
  - Expect out_src1 = 0xDEAD_BEEF, no stall.
- Load-use: rs2_raw = 1, rs2_forward = 0 for 2 cycles, then rs2_forward = 1 with value 0x55.
  - Expect in_ready = 0 for 2 cycles, two bubbles (out_valid = 0), stall_cnt = 2, then out_src2 = 0x55.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1.
  - Expect out_pc/out_src* stable and in_ready = 0.
  - On out_ready = 1 with in_valid, back-to-back load with out_valid staying 1.
- Flush: assert flush with out_valid = 1 and in_valid = 1 plus a hazard.
  - Expect out_valid = 0 next cycle, no capture, stall_cnt unchanged.
- Async reset mid-stream: drop reset_n between edges.
  - Expect out_valid and stall_cnt to go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_24110015_pkg.sv
// Shared types and constants for the NPC IDU/EXU boundary.
package ysyx_24110015_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IDEX_CTRL_W = 32;

    typedef logic [IDEX_CTRL_W-1:0] idex_ctrl_t;

    localparam logic [XLEN-1:0] RESET_PC_ZERO = '0;

endpackage

// File: rtl/ysyx_24110015_operand_sel.sv
// Resolves one source operand from the forward-check results.
module ysyx_24110015_operand_sel
    import ysyx_24110015_pkg::*;
(
    input  logic            raw,
    input  logic            forward,
    input  logic [XLEN-1:0] value,
    input  logic [XLEN-1:0] rf_rdata,
    output logic [XLEN-1:0] src,
    output logic            unresolved
);

    assign src        = forward ? value : rf_rdata;
    // A RAW that forwarding cannot cover must stall the instruction.
    assign unresolved = raw & ~forward;

endmodule

// File: rtl/ysyx_24110015_idex_reg.sv
// IDU->EXU stage register: operand resolution, valid/ready hold, bubbles on
// unresolvable hazards, flush on redirect and a hazard-stall counter.
module ysyx_24110015_idex_reg
    import ysyx_24110015_pkg::*;
#(
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic              rs1_raw,
    input  logic              rs2_raw,
    input  logic              rs1_forward,
    input  logic              rs2_forward,
    input  logic [31:0]       rs1_value,
    input  logic [31:0]       rs2_value,
    output logic              idu_processing,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_src1,
    output logic [31:0]       out_src2,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [XLEN-1:0]   w_src1;
    logic [XLEN-1:0]   w_src2;
    logic              w_unres1;
    logic              w_unres2;
    logic              w_hazard;
    logic              w_fire;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_src1;
    logic [XLEN-1:0]   r_src2;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_cnt;

    ysyx_24110015_operand_sel u_sel1 (
        .raw        (rs1_raw),
        .forward    (rs1_forward),
        .value      (rs1_value),
        .rf_rdata   (rf_rdata1),
        .src        (w_src1),
        .unresolved (w_unres1)
    );

    ysyx_24110015_operand_sel u_sel2 (
        .raw        (rs2_raw),
        .forward    (rs2_forward),
        .value      (rs2_value),
        .rf_rdata   (rf_rdata2),
        .src        (w_src2),
        .unresolved (w_unres2)
    );

    assign w_hazard       = in_valid & (w_unres1 | w_unres2);
    assign in_ready       = ~flush & ~w_hazard & (~r_valid | out_ready);
    assign w_fire         = in_valid & in_ready;
    assign idu_processing = in_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC_ZERO;
            r_src1  <= '0;
            r_src2  <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else begin
            // Flush wins; in_ready is already low so no capture can coincide.
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_fire) begin
                r_valid <= 1'b1;
                r_pc    <= in_pc;
                r_src1  <= w_src1;
                r_src2  <= w_src2;
                r_ctrl  <= in_ctrl;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_hazard && !flush) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_src1  = r_src1;
    assign out_src2  = r_src2;
    assign out_ctrl  = r_ctrl;
    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_ysyx_24110015_idex_reg.sv
// Directed plus randomized bench for the IDU->EXU stage register.
module tb_ysyx_24110015_idex_reg;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_ctrl;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        rs1_raw, rs2_raw, rs1_forward, rs2_forward;
    logic [31:0] rs1_value, rs2_value;
    logic        idu_processing, flush, out_valid, out_ready;
    logic [31:0] out_pc, out_src1, out_src2, out_ctrl, stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state: what EXU should currently see.
    logic        m_valid;
    logic [31:0] m_pc, m_src1, m_src2, m_ctrl, m_cnt;

    always #5 clock = ~clock;

    ysyx_24110015_idex_reg #(.CTRL_W(32), .CNT_W(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_ctrl        (in_ctrl),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .rs1_raw        (rs1_raw),
        .rs2_raw        (rs2_raw),
        .rs1_forward    (rs1_forward),
        .rs2_forward    (rs2_forward),
        .rs1_value      (rs1_value),
        .rs2_value      (rs2_value),
        .idu_processing (idu_processing),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_src1       (out_src1),
        .out_src2       (out_src2),
        .out_ctrl       (out_ctrl),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = '0;
        m_src1  = '0;
        m_src2  = '0;
        m_ctrl  = '0;
        m_cnt   = '0;
    endtask

    task automatic quiet();
        in_valid    = 1'b0;
        rs1_raw     = 1'b0;
        rs2_raw     = 1'b0;
        rs1_forward = 1'b0;
        rs2_forward = 1'b0;
        flush       = 1'b0;
    endtask

    // One clock: check combinational handshake, predict, clock, check state.
    task automatic cycle(input string tag);
        logic        stalled, rdy, take;
        logic [31:0] op1, op2;
        op1     = rs1_forward ? rs1_value : rf_rdata1;
        op2     = rs2_forward ? rs2_value : rf_rdata2;
        stalled = in_valid && ((rs1_raw && !rs1_forward) || (rs2_raw && !rs2_forward));
        rdy     = !flush && !stalled && (!m_valid || out_ready);
        take    = in_valid && rdy;
        #1;
        chk({tag, ".in_ready"}, in_ready, rdy);
        chk({tag, ".idu_proc"}, idu_processing, in_valid);
        if (flush) begin
            m_valid = 1'b0;
        end else if (take) begin
            m_valid = 1'b1;
            m_pc    = in_pc;
            m_src1  = op1;
            m_src2  = op2;
            m_ctrl  = in_ctrl;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (stalled && !flush) m_cnt = m_cnt + 1;
        @(posedge clock);
        #1;
        chk({tag, ".out_valid"}, out_valid, m_valid);
        chk({tag, ".stall_cnt"}, stall_cnt, m_cnt);
        if (m_valid) begin
            chk({tag, ".out_pc"},   out_pc,   m_pc);
            chk({tag, ".out_src1"}, out_src1, m_src1);
            chk({tag, ".out_src2"}, out_src2, m_src2);
            chk({tag, ".out_ctrl"}, out_ctrl, m_ctrl);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        quiet();
        out_ready = 1'b0;
        in_pc     = '0;
        in_ctrl   = '0;
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        rs1_value = '0;
        rs2_value = '0;
        model_reset();

        repeat (2) @(posedge clock);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_pc", out_pc, 0);
        chk("rst.out_src1", out_src1, 0);
        chk("rst.out_src2", out_src2, 0);
        chk("rst.out_ctrl", out_ctrl, 0);
        chk("rst.stall_cnt", stall_cnt, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Back-to-back stream with no hazards.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_pc     = 32'h8000_0000 + 32'(i * 4);
            in_ctrl   = $urandom;
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            cycle("stream");
        end
        chk("stream.last_pc", out_pc, 32'h8000_000C);

        // Forwarded operand overrides register-file data.
        in_pc       = 32'h8000_0010;
        rs1_raw     = 1'b1;
        rs1_forward = 1'b1;
        rs1_value   = 32'hDEAD_BEEF;
        rf_rdata1   = 32'h0000_1234;
        cycle("fwd");
        chk("fwd.src1", out_src1, 32'hDEAD_BEEF);

        // Load-use: two stalled cycles, then forwarding resolves it.
        quiet();
        in_valid    = 1'b1;
        in_pc       = 32'h8000_0014;
        rs2_raw     = 1'b1;
        rs2_value   = 32'h0000_0055;
        cycle("ldu1");
        cycle("ldu2");
        chk("ldu.cnt", stall_cnt, 2);
        rs2_forward = 1'b1;
        cycle("ldu3");
        chk("ldu.src2", out_src2, 32'h0000_0055);

        // Backpressure: outputs hold, then back-to-back reload.
        quiet();
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0018;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        chk("bp.held_pc", out_pc, 32'h8000_0014);
        out_ready = 1'b1;
        cycle("bp_release");

        // Flush while valid, with a pending hazard: no capture, no count.
        in_pc   = 32'h8000_001C;
        rs1_raw = 1'b1;
        flush   = 1'b1;
        cycle("flush");
        quiet();
        cycle("post_flush");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_pc       = $urandom;
            in_ctrl     = $urandom;
            rf_rdata1   = $urandom;
            rf_rdata2   = $urandom;
            rs1_value   = $urandom;
            rs2_value   = $urandom;
            rs1_raw     = ($urandom_range(3) == 0);
            rs2_raw     = ($urandom_range(3) == 0);
            rs1_forward = $urandom_range(1) == 1;
            rs2_forward = $urandom_range(1) == 1;
            out_ready   = ($urandom_range(3) != 0);
            flush       = ($urandom_range(15) == 0);
            cycle("rand");
        end

        // Ensure valid and nonzero count, then reset between edges.
        quiet();
        in_valid  = 1'b1;
        rs1_raw   = 1'b1;
        out_ready = 1'b1;
        cycle("pre_arst_stall");
        rs1_forward = 1'b1;
        cycle("pre_arst_fire");
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.stall_cnt", stall_cnt, 0);
        chk("arst.out_pc", out_pc, 0);
        model_reset();
        quiet();
        @(negedge clock);
        reset_n = 1'b1;
        cycle("post_arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
